cpu_opponent: RTL and testbench

Computer player for the cyber-war tug-of-war game. Runs a 10-bit XNOR LFSR on the game clock and compares the switch-selected difficulty against it. It then emits single-cycle "push" pulses that drive the R (player-2) input of the nine-light playfield. It sits directly upstream of the playfield light chain and replaces the human KEY[3] path. It adds a pacing state machine so the CPU cannot push on every tick.

---
 rtl/cpu_opponent.sv | 68 ++++++
 tb/tb_cpu_opponent.sv | 132 +++++++++++++
 2 files changed

// File: rtl/cpu_opponent.sv
// cpu_opponent: LFSR-paced CPU pusher for the tug-of-war R input; `CPU_COOLDOWN_EN adds the cooldown state
module cpu_opponent #(
  parameter int COOLDOWN = 2,
  parameter int LFSR_W   = 10
) (
  input  logic              clkSelect,
  input  logic              resetGame,
  input  logic              resetRound,
  input  logic              enable,
  input  logic [9:0]        threshold,
  output logic              cpu_press,
  output logic [LFSR_W-1:0] rnd,
  output logic [1:0]        state,
  output logic [7:0]        press_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, COOL = 2'd2} st_t;
  st_t  st;
  logic hit;
`ifdef CPU_COOLDOWN_EN
  logic [3:0] cnt;
`endif
  if (LFSR_W != 10 || COOLDOWN < 1 || COOLDOWN > 15) begin : g_bad_param
    $error("cpu_opponent: LFSR_W must be 10 and COOLDOWN 1..15");
  end
  assign hit   = threshold > rnd;
  assign state = st;
  // XNOR LFSR free-runs every edge so the sequence never restarts mid-game
  always_ff @(posedge clkSelect or posedge resetGame)
    if (resetGame) rnd <= '0;
    else rnd <= {rnd[8:0], ~(rnd[9] ^ rnd[6])};
  // pacing FSM: arm on enable, push on hit, then optionally sit out the cooldown
  always_ff @(posedge clkSelect or posedge resetGame)
    if (resetGame) begin
      st          <= IDLE;
      cpu_press   <= 1'b0;
      press_count <= 8'd0;
`ifdef CPU_COOLDOWN_EN
      cnt         <= 4'd0;
`endif
    end else if (resetRound || !enable) begin
      st          <= IDLE;
      cpu_press   <= 1'b0;
      press_count <= resetRound ? 8'd0 : press_count;
`ifdef CPU_COOLDOWN_EN
      cnt         <= 4'd0;
`endif
    end else begin
      cpu_press <= 1'b0;
      case (st)
        IDLE: st <= ARMED;
        ARMED:
          if (hit) begin
            cpu_press   <= 1'b1;
            press_count <= press_count + {7'd0, press_count != 8'hFF};
`ifdef CPU_COOLDOWN_EN
            cnt         <= 4'(COOLDOWN);
            st          <= COOL;
`endif
          end
`ifdef CPU_COOLDOWN_EN
        COOL:
          if (cnt == 4'd1) st <= ARMED;
          else cnt <= cnt - 4'd1;
`endif
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cpu_opponent.sv
// tb_cpu_opponent: scoreboard bench for cpu_opponent (both CPU_COOLDOWN_EN builds)
module tb_cpu_opponent;
  localparam int CD = 2;
  logic       clkSelect = 1'b0;
  logic       resetGame = 1'b1;
  logic       resetRound = 1'b0;
  logic       enable = 1'b0;
  logic [9:0] threshold = 10'd0;
  logic       cpu_press;
  logic [9:0] rnd;
  logic [1:0] state;
  logic [7:0] press_count;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {logic [9:0] r; logic p; logic [1:0] s; logic [7:0] c;} exp_t;
  exp_t sb[$];
  logic [9:0] m_r;
  logic [1:0] m_s;
  logic [3:0] m_cnt;
  logic       m_p;
  logic [7:0] m_c;
  int max_run;
  cpu_opponent #(.COOLDOWN(CD), .LFSR_W(10)) dut (
    .clkSelect(clkSelect), .resetGame(resetGame), .resetRound(resetRound),
    .enable(enable), .threshold(threshold), .cpu_press(cpu_press),
    .rnd(rnd), .state(state), .press_count(press_count)
  );
  always #5 clkSelect = ~clkSelect;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask
  task automatic model_reset();
    m_r = 10'd0; m_s = 2'd0; m_cnt = 4'd0; m_p = 1'b0; m_c = 8'd0;
  endtask
  // reference behaviour of one clock edge, evaluated on pre-edge state and inputs
  task automatic model_step();
    logic h;
    h = threshold > m_r;
    if (resetRound) begin
      m_s = 0; m_cnt = 0; m_p = 0; m_c = 0;
    end else if (!enable) begin
      m_s = 0; m_cnt = 0; m_p = 0;
    end else if (m_s == 0) begin
      m_s = 1; m_p = 0;
    end else if (m_s == 1) begin
      m_p = h;
      if (h) begin
        if (m_c != 8'hFF) m_c = m_c + 1;
`ifdef CPU_COOLDOWN_EN
        m_cnt = CD; m_s = 2;
`endif
      end
    end else begin
      m_p = 0;
      if (m_cnt == 1) m_s = 1;
      else m_cnt = m_cnt - 1;
    end
    m_r = {m_r[8:0], ~(m_r[9] ^ m_r[6])};
  endtask
  // drive at negedge, push expectation, compare just after the active edge
  task automatic tick(input logic en, input logic rr, input logic [9:0] th);
    exp_t e;
    exp_t g;
    enable = en; resetRound = rr; threshold = th;
    model_step();
    e.r = m_r; e.p = m_p; e.s = m_s; e.c = m_c;
    sb.push_back(e);
    @(posedge clkSelect);
    #1;
    g = sb.pop_front();
    check("rnd", rnd, g.r);
    check("cpu_press", cpu_press, g.p);
    check("state", state, g.s);
    check("press_count", press_count, g.c);
    if (cpu_press) max_run++;
    @(negedge clkSelect);
  endtask
  initial begin
    logic [9:0] seq [8];
    seq = '{10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F, 10'h03F, 10'h07F, 10'h0FE};
    model_reset();
    max_run = 0;
    #2;
    check("reset_rnd", rnd, 0);
    check("reset_press", cpu_press, 0);
    check("reset_state", state, 0);
    check("reset_count", press_count, 0);
    @(negedge clkSelect);
    resetGame = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 10'd0);
      check("lfsr_seq", rnd, seq[i]);
    end
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 10'h3FF);
    for (int i = 0; i < 300; i++) tick(1'b1, 1'b0, 10'h3FF);
`ifdef CPU_COOLDOWN_EN
    check("count_paced", press_count, 8'd104);
`else
    check("count_saturated", press_count, 8'hFF);
`endif
    tick(1'b1, 1'b1, 10'h3FF);
    check("round_clear", press_count, 0);
    tick(1'b0, 1'b0, 10'h3FF);
    tick(1'b1, 1'b0, 10'h3FF);
    tick(1'b1, 1'b0, 10'h3FF);
    tick(1'b0, 1'b0, 10'h3FF);
    check("drop_idle", state, 0);
    tick(1'b1, 1'b0, 10'h000);
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 10'h000);
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 7) != 0, $urandom_range(0, 40) == 0, 10'($urandom_range(0, 1023)));
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 10'h3FF);
    #2;
    resetGame = 1'b1;
    #1;
    check("async_rnd", rnd, 0);
    check("async_press", cpu_press, 0);
    check("async_state", state, 0);
    check("async_count", press_count, 0);
    model_reset();
    @(negedge clkSelect);
    resetGame = 1'b0;
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 10'h3FF);
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
